// File: rtl/seg_disp_sched.sv
// seg_disp_sched: display scheduler for an 8-digit serial 7-segment display behind a
// 74HC595-style shift chain. It holds four 32-bit channels, picks one as the page
// (debounced key, optional auto-scroll), snapshots it per frame and serialises each digit.
// Optional feature macro: SEG_AUTO_SCROLL_EN (auto page advance every AUTO_FRAMES frames).
module seg_disp_sched #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned DB_CYC      = 250000,
    parameter int unsigned AUTO_FRAMES = 200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_n,
    input  logic [3:0]   ch_en,
    input  logic [3:0]   ch_vld,
    input  logic [127:0] ch_data,
    output logic         ds,
    output logic         shclk,
    output logic         stclk,
    output logic [1:0]   page,
    output logic         frame_done
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DbW  = $clog2(DB_CYC + 1);

    // Next enabled index after cur (wrapping); cur itself when no other index is enabled.
    function automatic logic [1:0] next_page(input logic [1:0] cur, input logic [3:0] en);
        logic [1:0] res;
        logic [1:0] idx;
        res = cur;
        for (int k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (en[idx]) res = idx;
        end
        return res;
    endfunction

    logic [DivW-1:0]      div_cnt_q, div_cnt_d;
    logic                 tick;
    logic [5:0]           slot_q, slot_d;
    logic [2:0]           digit_q, digit_d;
    logic                 frame_start;
    logic [3:0][31:0]     held_q, held_d;
    logic [31:0]          shadow_q, shadow_d;
    logic [1:0]           page_q, page_d;
    logic [1:0]           nxt_page;
    logic [1:0]           snap_page;
    logic                 fix_now;
    logic                 ds_q, ds_d;
    logic                 shclk_q, shclk_d;
    logic                 stclk_q, stclk_d;
    logic                 frame_done_q, frame_done_d;
    logic [3:0]           nib;
    logic [7:0]           seg_pat;
    logic [7:0]           pat;
    logic [7:0]           sel;
    logic [15:0]          word;
    logic [1:0]           sync_q, sync_d;
    logic                 lvl_q, lvl_d;
    logic                 acc_q, acc_d;
    logic [DbW-1:0]       db_cnt_q, db_cnt_d;
    logic                 press;
    logic                 auto_adv;

    assign tick        = (div_cnt_q == DivW'(CLK_DIV - 1));
    assign frame_start = tick && (slot_q == 6'd0) && (digit_q == 3'd0);

    // Tick divider and slot/digit position counters.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
        slot_d    = slot_q;
        digit_d   = digit_q;
        if (tick) begin
            if (slot_q == 6'd33) begin
                slot_d  = 6'd0;
                digit_d = digit_q + 3'd1;
            end else begin
                slot_d = slot_q + 6'd1;
            end
        end
    end

    // Page selection; a disabled page is corrected at the frame boundary before the snapshot.
    always_comb begin
        nxt_page  = next_page(page_q, ch_en);
        fix_now   = frame_start && !ch_en[page_q];
        snap_page = fix_now ? nxt_page : page_q;
        page_d    = (press || auto_adv || fix_now) ? nxt_page : page_q;
    end

    // Channel holding registers and the per-frame shadow snapshot.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < 4; i++) begin
            if (ch_vld[i]) held_d[i] = ch_data[32*i +: 32];
        end
        // Snapshot reads held_q, so a same-cycle update lands in the following frame.
        shadow_d = frame_start ? held_q[snap_page] : shadow_q;
    end

    // Digit word: select byte over an active-low hex pattern, shifted out LSB first.
    always_comb begin
        nib = shadow_d[{digit_q, 2'b00} +: 4];
        case (nib)
            4'h0:    seg_pat = 8'h03;
            4'h1:    seg_pat = 8'h9F;
            4'h2:    seg_pat = 8'h25;
            4'h3:    seg_pat = 8'h0D;
            4'h4:    seg_pat = 8'h99;
            4'h5:    seg_pat = 8'h49;
            4'h6:    seg_pat = 8'h41;
            4'h7:    seg_pat = 8'h1F;
            4'h8:    seg_pat = 8'h01;
            4'h9:    seg_pat = 8'h09;
            4'hA:    seg_pat = 8'h11;
            4'hB:    seg_pat = 8'hC1;
            4'hC:    seg_pat = 8'h63;
            4'hD:    seg_pat = 8'h85;
            4'hE:    seg_pat = 8'h61;
            default: seg_pat = 8'h71;
        endcase
        pat  = (ch_en == 4'd0) ? 8'hFF : seg_pat;
        sel  = 8'd1 << digit_q;
        word = {sel, pat};
    end

    // Serial output sequencing within a 34-tick digit slot.
    always_comb begin
        ds_d         = ds_q;
        shclk_d      = shclk_q;
        stclk_d      = stclk_q;
        frame_done_d = tick && (slot_q == 6'd33) && (digit_q == 3'd7);
        if (tick) begin
            if (!slot_q[5]) begin
                if (!slot_q[0]) begin
                    ds_d    = word[slot_q[4:1]];
                    shclk_d = 1'b0;
                end else begin
                    shclk_d = 1'b1;
                end
            end else if (slot_q == 6'd32) begin
                stclk_d = 1'b1;
            end else begin
                stclk_d = 1'b0;
            end
        end
    end

    // Key synchroniser and debounce; a press is an accepted high-to-low change.
    always_comb begin
        sync_d   = {sync_q[0], key_n};
        lvl_d    = lvl_q;
        db_cnt_d = db_cnt_q;
        acc_d    = acc_q;
        press    = 1'b0;
        if (sync_q[1] != lvl_q) begin
            lvl_d    = sync_q[1];
            db_cnt_d = '0;
        end else if (db_cnt_q != DbW'(DB_CYC)) begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end
        if ((db_cnt_q == DbW'(DB_CYC)) && (acc_q != lvl_q)) begin
            acc_d = lvl_q;
            press = acc_q && !lvl_q;
        end
    end

`ifdef SEG_AUTO_SCROLL_EN
    localparam int unsigned FcW = $clog2(AUTO_FRAMES + 1);

    logic [FcW-1:0] frame_cnt_q, frame_cnt_d;

    // Frame counter for auto-scroll; a press restarts the dwell time.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        auto_adv    = 1'b0;
        if (press) begin
            frame_cnt_d = '0;
        end else if (frame_done_q) begin
            if (frame_cnt_q == FcW'(AUTO_FRAMES - 1)) begin
                frame_cnt_d = '0;
                auto_adv    = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FcW'(1);
            end
        end
    end

    // Auto-scroll frame counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end
`else
    logic unused_auto_frames;
    assign unused_auto_frames = ^(32'(AUTO_FRAMES));
    assign auto_adv           = 1'b0;
`endif

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            slot_q       <= '0;
            digit_q      <= '0;
            held_q       <= '0;
            shadow_q     <= '0;
            page_q       <= '0;
            ds_q         <= 1'b0;
            shclk_q      <= 1'b0;
            stclk_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sync_q       <= 2'b11;
            lvl_q        <= 1'b1;
            acc_q        <= 1'b1;
            db_cnt_q     <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            slot_q       <= slot_d;
            digit_q      <= digit_d;
            held_q       <= held_d;
            shadow_q     <= shadow_d;
            page_q       <= page_d;
            ds_q         <= ds_d;
            shclk_q      <= shclk_d;
            stclk_q      <= stclk_d;
            frame_done_q <= frame_done_d;
            sync_q       <= sync_d;
            lvl_q        <= lvl_d;
            acc_q        <= acc_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    assign ds         = ds_q;
    assign shclk      = shclk_q;
    assign stclk      = stclk_q;
    assign page       = page_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: scoreboard bench for seg_disp_sched. Latched words are decoded from
// ds/shclk/stclk and compared against per-digit words pushed when stimulus is driven.
module tb_seg_disp_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_n = 1'b1;
    logic [3:0]   ch_en = 4'hF;
    logic [3:0]   ch_vld = 4'h0;
    logic [127:0] ch_data = '0;
    logic         ds;
    logic         shclk;
    logic         stclk;
    logic [1:0]   page;
    logic         frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] sh_reg = '0;
    logic [15:0] words[$];
    logic [15:0] exp_q[$];
    logic [7:0]  hex_lut [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    seg_disp_sched #(
        .CLK_DIV     (2),
        .DB_CYC      (4),
        .AUTO_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .ch_en      (ch_en),
        .ch_vld     (ch_vld),
        .ch_data    (ch_data),
        .ds         (ds),
        .shclk      (shclk),
        .stclk      (stclk),
        .page       (page),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Model of the shift/storage chain: first bit shifted ends up in bit 0.
    always @(posedge shclk) sh_reg <= {ds, sh_reg[15:1]};
    always @(posedge stclk) words.push_back(sh_reg);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [31:0] val, input logic [3:0] en);
        logic [7:0] sel;
        logic [7:0] pat;
        for (int d = 0; d < 8; d++) begin
            sel = 8'd1 << d;
            pat = (en == 4'd0) ? 8'hFF : hex_lut[val[4*d +: 4]];
            exp_q.push_back({sel, pat});
        end
    endtask

    task automatic wait_frame(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (found) n_pass++;
        else $display("FAIL %s: frame_done got none within 1200 cycles, required a pulse", name);
    endtask

    // Scoreboard drain: pop one frame of latched words against the expected queue.
    task automatic sb_compare(input string name);
        logic [15:0] got;
        logic [15:0] exp;
        for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (words.size() == 0 || exp_q.size() == 0) begin
                $display("FAIL %s digit %0d: got %0d words, required %0d", name, d,
                         words.size(), exp_q.size());
            end else begin
                got = words.pop_front();
                exp = exp_q.pop_front();
                if (got !== exp)
                    $display("FAIL %s digit %0d: got %h required %h", name, d, got, exp);
                else n_pass++;
            end
        end
        words.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        key_n  = 1'b1;
        ch_vld = 4'h0;
        repeat (3) @(negedge clk);
        words.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic load(input int ch, input logic [31:0] val);
        ch_data[32*ch +: 32] = val;
        ch_vld               = 4'd1 << ch;
        @(negedge clk);
        ch_vld = 4'h0;
    endtask

    task automatic do_press();
        key_n = 1'b0;
        repeat (10) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ds, shclk, stclk, page, frame_done} !== 6'b0)
            $display("FAIL reset_outputs: got %b required 000000",
                     {ds, shclk, stclk, page, frame_done});
        else n_pass++;
    endtask

    task automatic test_frame();
        int cyc;
        bit found;
        do_reset();
        ch_en = 4'hF;
        load(0, 32'h0000_00A5);
        push_frame(32'h0000_00A5, 4'hF);
        cyc   = 1;
        found = 1'b0;
        while (!found && cyc < 1200) begin
            if (cyc == 65 || cyc == 66) begin
                n_checks++;
                if (stclk !== (cyc == 66))
                    $display("FAIL stclk_s32 cyc %0d: got %b required %b", cyc, stclk, cyc == 66);
                else n_pass++;
            end
            if (frame_done) found = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        n_checks++;
        if (!found || cyc != 544)
            $display("FAIL frame_len: got frame_done at cycle %0d, required 544", cyc);
        else n_pass++;
        sb_compare("frame_a5");
    endtask

    task automatic test_debounce();
        do_reset();
        ch_en = 4'hF;
        load(1, 32'hFEDC_BA98);
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (page !== 2'd0) $display("FAIL glitch_page: got %0d required 0", page);
        else n_pass++;
        do_press();
        n_checks++;
        if (page !== 2'd1) $display("FAIL press_page: got %0d required 1", page);
        else n_pass++;
        wait_frame("debounce_align");
        words.delete();
        push_frame(32'hFEDC_BA98, 4'hF);
        wait_frame("debounce_frame");
        sb_compare("page1_frame");
    endtask

    task automatic test_enable();
        do_reset();
        ch_en = 4'b0101;
        do_press();
        n_checks++;
        if (page !== 2'd2) $display("FAIL skip_page_a: got %0d required 2", page);
        else n_pass++;
        do_press();
        n_checks++;
        if (page !== 2'd0) $display("FAIL skip_page_b: got %0d required 0", page);
        else n_pass++;
        ch_en = 4'b0000;
        wait_frame("blank_align");
        words.delete();
        push_frame(32'h0, 4'b0000);
        wait_frame("blank_frame");
        sb_compare("blank");
        @(negedge clk);
        n_checks++;
        if (page !== 2'd0) $display("FAIL blank_page: got %0d required 0", page);
        else n_pass++;
    endtask

    task automatic test_midframe();
        do_reset();
        ch_en = 4'hF;
        load(0, 32'h0BAD_F00D);
        repeat (100) @(negedge clk);
        load(0, 32'h1234_5678);
        push_frame(32'h0BAD_F00D, 4'hF);
        wait_frame("mid_old");
        sb_compare("mid_old");
        push_frame(32'h1234_5678, 4'hF);
        wait_frame("mid_new");
        sb_compare("mid_new");
    endtask

    task automatic test_autoscroll();
        do_reset();
        ch_en = 4'hF;
`ifdef SEG_AUTO_SCROLL_EN
        wait_frame("auto_f1");
        @(negedge clk);
        n_checks++;
        if (page !== 2'd0) $display("FAIL auto_f1: got %0d required 0", page);
        else n_pass++;
        wait_frame("auto_f2");
        @(negedge clk);
        n_checks++;
        if (page !== 2'd1) $display("FAIL auto_f2: got %0d required 1", page);
        else n_pass++;
        wait_frame("auto_f3");
        @(negedge clk);
        do_press();
        n_checks++;
        if (page !== 2'd2) $display("FAIL auto_press: got %0d required 2", page);
        else n_pass++;
        wait_frame("auto_f4");
        @(negedge clk);
        n_checks++;
        if (page !== 2'd2) $display("FAIL auto_cnt_cleared: got %0d required 2", page);
        else n_pass++;
        wait_frame("auto_f5");
        @(negedge clk);
        n_checks++;
        if (page !== 2'd3) $display("FAIL auto_f5: got %0d required 3", page);
        else n_pass++;
`else
        for (int f = 0; f < 3; f++) begin
            wait_frame("noauto");
            @(negedge clk);
            n_checks++;
            if (page !== 2'd0) $display("FAIL noauto_f%0d: got %0d required 0", f, page);
            else n_pass++;
        end
`endif
    endtask

    task automatic test_reset_midframe();
        do_reset();
        ch_en = 4'hF;
        load(0, 32'hDEAD_BEEF);
        do_press();
        wait_frame("rst_align");
        // Slot 17 of digit 3 is tick index 119 after the frame boundary.
        repeat (240) @(negedge clk);
        n_checks++;
        if ({shclk, stclk, page} !== 4'b1001)
            $display("FAIL pre_reset_state: got %b required 1001", {shclk, stclk, page});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ds, shclk, stclk, page, frame_done} !== 6'b0)
            $display("FAIL midframe_reset: got %b required 000000",
                     {ds, shclk, stclk, page, frame_done});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        words.delete();
        exp_q.delete();
        rst_n = 1'b1;
        push_frame(32'h0, 4'hF);
        wait_frame("after_reset");
        sb_compare("after_reset");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_debounce();
        test_enable();
        test_midframe();
        test_autoscroll();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
